// File: rtl/jedro_1_ifu_pkg.sv
// Shared constants and types for the jedro_1 instruction fetch unit.
package jedro_1_ifu_pkg;

  // Default instruction/address width and reset PC of the core.
  localparam int unsigned IFU_DATA_WIDTH = 32;
  localparam logic [31:0] IFU_BOOT_ADDR  = 32'h0000_0000;

  // Byte distance between consecutive instruction words.
  localparam int unsigned IFU_PC_STEP = 4;

  // What happens to the memory response seen in the current cycle.
  typedef enum logic [1:0] {
    RESP_NONE    = 2'd0,  // no response, or nothing outstanding to match it
    RESP_DROP    = 2'd1,  // stale response from before a redirect
    RESP_DISCARD = 2'd2,  // response thrown away (redirect this cycle or halted)
    RESP_PUSH    = 2'd3   // response written into the prefetch FIFO
  } resp_act_e;

  // True when the response retires one outstanding request.
  function automatic logic resp_retires(input resp_act_e act);
    logic ret;
    case (act)
      RESP_DROP, RESP_DISCARD, RESP_PUSH: ret = 1'b1;
      RESP_NONE:                          ret = 1'b0;
      default:                            ret = 1'b0;
    endcase
    return ret;
  endfunction

endpackage

// File: rtl/jedro_1_ifu_if.sv
// Instruction memory bus between the fetch unit (master) and memory (slave).
interface jedro_1_ifu_if
  import jedro_1_ifu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = IFU_DATA_WIDTH
);
  logic                  req;
  logic                  gnt;
  logic [DATA_WIDTH-1:0] addr;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata,
    input  err
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata,
    output err
  );
endinterface

// File: rtl/jedro_1_fifo.sv
// Synchronous FIFO with flush; head word is read straight from the storage
// registers so a push is visible on data_o the cycle after it happens.
module jedro_1_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop_s;
  logic             do_push_s;

  // Qualify push/pop; a push into a full FIFO is legal only alongside a pop.
  always_comb begin
    do_pop_s  = pop_i && (count_q != {CNT_W{1'b0}});
    do_push_s = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop_s);
  end

  // Storage, pointers and occupancy; flush empties the FIFO after any pop.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else if (flush_i) begin
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign count_o = count_q;

endmodule

// File: rtl/jedro_1_ifu.sv
// jedro_1 instruction fetch unit: keeps several fetches in flight, buffers
// returned words with their PCs, handles redirects and bus errors.
module jedro_1_ifu
  import jedro_1_ifu_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH      = IFU_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] BOOT_ADDR       = DATA_WIDTH'(IFU_BOOT_ADDR),
  parameter int unsigned           FIFO_DEPTH      = 4,
  parameter int unsigned           MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  jedro_1_ifu_if.master         instr_bus,
  input  logic                  jmp_i,
  input  logic [DATA_WIDTH-1:0] jmp_addr_i,
  output logic                  dec_valid_o,
  input  logic                  dec_ready_i,
  output logic [DATA_WIDTH-1:0] dec_instr_o,
  output logic [DATA_WIDTH-1:0] dec_pc_o,
  output logic                  dec_err_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned ENT_W = 2 * DATA_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(IFU_PC_STEP);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

  // Architectural state
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
  logic                  halted_q, halted_d;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;

  // Per-cycle decode
  resp_act_e             resp_act_s;
  logic                  grant_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  credit_s;
  logic [CNT_W-1:0]      fifo_cnt_next_s;
  logic [DATA_WIDTH-1:0] jmp_tgt_s;

  // FIFO connections
  logic [ENT_W-1:0]      fifo_din_s;
  logic [ENT_W-1:0]      fifo_dout_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [CNT_W-1:0]      fifo_count_s;

  assign grant_s   = req_q && instr_bus.gnt;
  assign pop_s     = !fifo_empty_s && dec_ready_i;
  assign jmp_tgt_s = jmp_addr_i & ALIGN_MASK;

  // Classify the incoming response: stale, thrown away, or buffered.
  always_comb begin
    resp_act_s = RESP_NONE;
    if (!instr_bus.rvalid || (outstanding_q == {CNT_W{1'b0}})) begin
      resp_act_s = RESP_NONE;
    end else if (drop_cnt_q != {CNT_W{1'b0}}) begin
      resp_act_s = RESP_DROP;
    end else if (jmp_i || halted_q || (fifo_full_s && !pop_s)) begin
      // The full-FIFO guard cannot trigger while the credit rule holds.
      resp_act_s = RESP_DISCARD;
    end else begin
      resp_act_s = RESP_PUSH;
    end
  end

  // Next-state for counters, PCs, halt flag and the registered request.
  always_comb begin
    push_s          = (resp_act_s == RESP_PUSH);
    outstanding_d   = outstanding_q + CNT_W'(grant_s)
                      - CNT_W'(resp_retires(resp_act_s));
    fetch_pc_d      = fetch_pc_q;
    resp_pc_d       = resp_pc_q;
    drop_cnt_d      = drop_cnt_q;
    halted_d        = halted_q;
    fifo_cnt_next_s = fifo_count_s;
    if (jmp_i) begin
      // Everything still in flight after this cycle belongs to the old stream.
      fetch_pc_d      = jmp_tgt_s;
      resp_pc_d       = jmp_tgt_s;
      drop_cnt_d      = outstanding_d;
      halted_d        = 1'b0;
      fifo_cnt_next_s = {CNT_W{1'b0}};
    end else begin
      fetch_pc_d      = fetch_pc_q + (grant_s ? STEP : {DATA_WIDTH{1'b0}});
      resp_pc_d       = resp_pc_q + (push_s ? STEP : {DATA_WIDTH{1'b0}});
      drop_cnt_d      = drop_cnt_q - CNT_W'(resp_act_s == RESP_DROP);
      halted_d        = halted_q || (push_s && instr_bus.err);
      fifo_cnt_next_s = fifo_count_s + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // Responses still to be buffered plus buffered words must fit the FIFO.
    credit_s = !halted_d
               && (outstanding_d < CNT_W'(MAX_OUTSTANDING))
               && ((SUM_W'(outstanding_d - drop_cnt_d) + SUM_W'(fifo_cnt_next_s))
                   < SUM_W'(FIFO_DEPTH));

    if (jmp_i) begin
      req_d = credit_s;
    end else if (req_q && !grant_s) begin
      // An issued request is held with its address until it is granted.
      req_d = 1'b1;
    end else begin
      req_d = credit_s;
    end
    addr_d = fetch_pc_d;
  end

  // State registers, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      fetch_pc_q    <= BOOT_ADDR;
      resp_pc_q     <= BOOT_ADDR;
      outstanding_q <= {CNT_W{1'b0}};
      drop_cnt_q    <= {CNT_W{1'b0}};
      halted_q      <= 1'b0;
      req_q         <= 1'b0;
      addr_q        <= BOOT_ADDR;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      halted_q      <= halted_d;
      req_q         <= req_d;
      addr_q        <= addr_d;
    end
  end

  assign instr_bus.req  = req_q;
  assign instr_bus.addr = addr_q;

  // Entry layout: {instruction, pc, error}
  assign fifo_din_s = {instr_bus.rdata, resp_pc_q, instr_bus.err};

  jedro_1_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push_s),
    .data_i  (fifo_din_s),
    .pop_i   (pop_s),
    .flush_i (jmp_i),
    .data_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  assign dec_valid_o = !fifo_empty_s;
  assign dec_instr_o = fifo_dout_s[ENT_W-1 -: DATA_WIDTH];
  assign dec_pc_o    = fifo_dout_s[DATA_WIDTH:1];
  assign dec_err_o   = fifo_dout_s[0];

endmodule

// File: tb/tb_jedro_1_ifu.sv
// Directed testbench for jedro_1_ifu with an in-order latency memory model.
module tb_jedro_1_ifu;

  logic        clk = 1'b0;
  logic        rstn;
  logic        jmp;
  logic [31:0] jmp_addr;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int grant_cnt;
  int lat;
  bit gnt_en;
  bit err_en;
  logic [31:0] err_addr;

  logic [31:0] rq_addr[$];
  int          rq_due[$];
  logic [31:0] gaddr[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];
  logic        pop_err[$];

  always #5 clk = ~clk;

  jedro_1_ifu_if #(.DATA_WIDTH(32)) bus ();

  jedro_1_ifu #(
    .DATA_WIDTH      (32),
    .BOOT_ADDR       (32'h0000_0000),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .instr_bus   (bus),
    .jmp_i       (jmp),
    .jmp_addr_i  (jmp_addr),
    .dec_valid_o (dec_valid),
    .dec_ready_i (dec_ready),
    .dec_instr_o (dec_instr),
    .dec_pc_o    (dec_pc),
    .dec_err_o   (dec_err)
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive memory/decoder inputs from current outputs, then advance one cycle.
  task automatic step();
    if (rq_addr.size() > 0 && rq_due[0] <= cyc) begin
      bus.rvalid = 1'b1;
      bus.rdata  = data_of(rq_addr[0]);
      bus.err    = err_en && (rq_addr[0] == err_addr);
      void'(rq_addr.pop_front());
      void'(rq_due.pop_front());
    end else begin
      bus.rvalid = 1'b0;
      bus.rdata  = 32'h0;
      bus.err    = 1'b0;
    end
    bus.gnt = gnt_en;
    if (bus.req === 1'b1 && gnt_en) begin
      rq_addr.push_back(bus.addr);
      rq_due.push_back(cyc + lat);
      gaddr.push_back(bus.addr);
      grant_cnt++;
    end
    if (rstn && dec_valid === 1'b1 && dec_ready) begin
      pop_pc.push_back(dec_pc);
      pop_instr.push_back(dec_instr);
      pop_err.push_back(dec_err);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    rq_addr.delete(); rq_due.delete(); gaddr.delete();
    pop_pc.delete(); pop_instr.delete(); pop_err.delete();
    grant_cnt = 0;
  endtask

  // Two reset cycles with a clean memory model; release on the next step.
  task automatic do_reset();
    rstn = 1'b0;
    jmp  = 1'b0;
    step();
    step();
    clear_logs();
    rstn = 1'b1;
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_req"},   bus.req,   32'h0);
    check_eq({pfx, "_addr"},  bus.addr,  32'h0000_0000);
    check_eq({pfx, "_valid"}, dec_valid, 32'h0);
    check_eq({pfx, "_instr"}, dec_instr, 32'h0);
    check_eq({pfx, "_pc"},    dec_pc,    32'h0);
    check_eq({pfx, "_err"},   dec_err,   32'h0);
  endtask

  initial begin
    int vcnt;
    int stable;
    rstn = 1'b0; jmp = 1'b0; jmp_addr = 32'h0; dec_ready = 1'b0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.err = 1'b0;
    lat = 1; gnt_en = 1'b1; err_en = 1'b0; err_addr = 32'h0;
    grant_cnt = 0;

    // 1) streaming fetch, one instruction per cycle
    do_reset();
    check_reset_vals("rst");
    dec_ready = 1'b1;
    step();
    check_eq("first_req", bus.req, 32'h1);
    check_eq("first_addr", bus.addr, 32'h0);
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (dec_valid === 1'b1) vcnt++;
    end
    check_eq("stream_valid_cycles", vcnt, 32'd9);
    check_eq("stream_pops", pop_pc.size(), 32'd8);
    for (int i = 0; i < 4; i++) begin
      check_eq("stream_gaddr", gaddr[i], 32'(i * 4));
      check_eq("stream_pc", pop_pc[i], 32'(i * 4));
      check_eq("stream_instr", pop_instr[i], data_of(32'(i * 4)));
    end

    // 2) decoder stalled: four grants fill the FIFO, then drain in order
    dec_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) step();
    check_eq("bp_grants", grant_cnt, 32'd4);
    check_eq("bp_req_low", bus.req, 32'h0);
    check_eq("bp_head_pc", dec_pc, 32'h0);
    dec_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_pop_pc", pop_pc[i], 32'(i * 4));
    end
    check_eq("bp_resume_addr", gaddr[4], 32'h10);

    // 3) grant withheld: request and address held stable
    gnt_en = 1'b0;
    do_reset();
    step();
    stable = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.req === 1'b1 && bus.addr === 32'h0) stable++;
      step();
    end
    check_eq("hold_stable", stable, 32'd5);
    gnt_en = 1'b1;
    step();
    check_eq("hold_next_addr", bus.addr, 32'h4);

    // 4) redirect with two requests in flight, then redirect with full FIFO
    lat = 3;
    do_reset();
    step();
    step();
    step();
    check_eq("jmp_pre_req", bus.req, 32'h0);
    jmp = 1'b1; jmp_addr = 32'h0000_0103;
    step();
    jmp = 1'b0;
    check_eq("jmp_valid_off", dec_valid, 32'h0);
    for (int i = 0; i < 10; i++) step();
    check_eq("jmp_gaddr", gaddr[2], 32'h100);
    check_eq("jmp_first_pc", pop_pc[0], 32'h100);
    check_eq("jmp_first_instr", pop_instr[0], data_of(32'h100));
    check_eq("jmp_second_pc", pop_pc[1], 32'h104);
    dec_ready = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check_eq("flush_pre_valid", dec_valid, 32'h1);
    jmp = 1'b1; jmp_addr = 32'h0000_0200;
    step();
    jmp = 1'b0;
    check_eq("flush_valid_off", dec_valid, 32'h0);
    check_eq("flush_req", bus.req, 32'h1);
    check_eq("flush_addr", bus.addr, 32'h200);
    pop_pc.delete(); pop_instr.delete(); pop_err.delete();
    dec_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check_eq("flush_first_pc", pop_pc[0], 32'h200);

    // 5) bus error halts fetch; redirect resumes
    lat = 1; err_en = 1'b1; err_addr = 32'h8;
    do_reset();
    step();
    for (int i = 0; i < 10; i++) step();
    check_eq("err_pops", pop_pc.size(), 32'd3);
    check_eq("err_pc", pop_pc[2], 32'h8);
    check_eq("err_flag", pop_err[2], 32'h1);
    check_eq("err_prev_flag", pop_err[1], 32'h0);
    check_eq("err_grants", grant_cnt, 32'd4);
    check_eq("err_req_low", bus.req, 32'h0);
    jmp = 1'b1; jmp_addr = 32'h0000_0040;
    step();
    jmp = 1'b0;
    check_eq("err_jmp_req", bus.req, 32'h1);
    check_eq("err_jmp_addr", bus.addr, 32'h40);
    for (int i = 0; i < 6; i++) step();
    check_eq("err_resume_pc", pop_pc[3], 32'h40);
    check_eq("err_resume_flag", pop_err[3], 32'h0);
    err_en = 1'b0;

    // 6) reset with two requests outstanding; late responses ignored
    lat = 3;
    do_reset();
    step();
    step();
    step();
    rstn = 1'b0;
    step();
    check_reset_vals("midrst");
    step();
    rstn = 1'b1;
    for (int i = 0; i < 9; i++) step();
    check_eq("midrst_pc", pop_pc[0], 32'h0);
    check_eq("midrst_instr", pop_instr[0], data_of(32'h0));
    check_eq("midrst_pc2", pop_pc[1], 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
